// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU operation at a time.
// It accepts a request, drives the decoded ALU control lines for the full
// pipeline occupancy, captures the ALU result and zero flag, and returns
// them on a response handshake.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a request; control lines keep their last-issued values
// WAIT  | legal op issued; down-counter runs to the result-capture edge
// DONE  | response presented; held until the consumer takes it
module alu_op_sequencer #(
  parameter int LAT   = 17,
  parameter int CNT_W = 16
) (
  input  logic             clkpos,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [1:0]       req_bsel,
  input  logic             req_asel,
  input  logic [1:0]       req_osel,
  input  logic [15:0]      alu_result,
  input  logic             alu_zero,
  output logic             alu_control0,
  output logic             alu_control1,
  output logic             sub,
  output logic             stl,
  output logic             adder_cin,
  output logic             b_mux0,
  output logic             b_mux1,
  output logic             a_mux,
  output logic             mux3_0,
  output logic             mux3_1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // The accept edge loads LAT-1 so that the counter reads zero on edge E+LAT.
  localparam logic [7:0] CNT_LOAD = 8'(LAT - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  // {alu_control1, alu_control0, sub, stl, adder_cin, b_mux1, b_mux0, a_mux, mux3_1, mux3_0}
  logic [9:0]       ctrl, ctrl_nxt;
  logic             rsp_valid_nxt, rsp_zero_nxt, rsp_err_nxt;
  logic [15:0]      rsp_data_nxt;
  logic [CNT_W-1:0] op_count_nxt;

  logic [1:0]       dec_alu;
  logic             dec_sub, dec_stl, dec_cin, dec_legal;

  // Opcode decode onto the static ALU lines; 110 and 111 are illegal.
  always_comb begin
    dec_alu   = 2'b00;
    dec_sub   = 1'b0;
    dec_stl   = 1'b0;
    dec_cin   = 1'b0;
    dec_legal = 1'b1;
    case (req_op)
      3'b000: dec_alu = 2'b00;
      3'b001: dec_alu = 2'b01;
      3'b010: dec_alu = 2'b10;
      3'b011: begin
        dec_alu = 2'b10;
        dec_cin = 1'b1;
      end
      3'b100: begin
        dec_alu = 2'b10;
        dec_sub = 1'b1;
        dec_cin = 1'b1;
      end
      3'b101: begin
        dec_alu = 2'b11;
        dec_stl = 1'b1;
        dec_cin = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ctrl_nxt      = ctrl;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    rsp_zero_nxt  = rsp_zero;
    rsp_err_nxt   = rsp_err;
    op_count_nxt  = op_count;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (dec_legal) begin
            ctrl_nxt  = {dec_alu, dec_sub, dec_stl, dec_cin, req_bsel, req_asel, req_osel};
            cnt_nxt   = CNT_LOAD;
            state_nxt = WAIT;
          end else begin
            // Illegal op answers immediately and leaves the ALU lines alone.
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = 16'h0000;
            rsp_zero_nxt  = 1'b0;
            rsp_valid_nxt = 1'b1;
            state_nxt     = DONE;
          end
        end
      end
      WAIT: begin
        if (cnt == 8'd0) begin
          rsp_data_nxt  = alu_result;
          rsp_zero_nxt  = alu_zero;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          op_count_nxt  = op_count + CNT_W'(1);
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clkpos) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      ctrl      <= 10'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ctrl      <= ctrl_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_zero  <= rsp_zero_nxt;
      rsp_err   <= rsp_err_nxt;
      op_count  <= op_count_nxt;
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign alu_control1 = ctrl[9];
  assign alu_control0 = ctrl[8];
  assign sub          = ctrl[7];
  assign stl          = ctrl[6];
  assign adder_cin    = ctrl[5];
  assign b_mux1       = ctrl[4];
  assign b_mux0       = ctrl[3];
  assign a_mux        = ctrl[2];
  assign mux3_1       = ctrl[1];
  assign mux3_0       = ctrl[0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a table of operations with
// hand-decoded expected control lines and results, plus hand sequences for
// reset during WAIT and op_count wrap.
module tb_alu_op_sequencer;

  localparam int LAT   = 17;
  localparam int CNT_W = 4;

  logic             clkpos = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [1:0]       req_bsel;
  logic             req_asel;
  logic [1:0]       req_osel;
  logic [15:0]      alu_result;
  logic             alu_zero;
  logic             alu_control0, alu_control1, sub, stl, adder_cin;
  logic             b_mux0, b_mux1, a_mux, mux3_0, mux3_1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [9:0]       ctrl_obs;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [9:0] last_ctrl;
  int exp_cnt;

  always #5 clkpos = ~clkpos;

  alu_op_sequencer #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clkpos(clkpos), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_bsel(req_bsel), .req_asel(req_asel), .req_osel(req_osel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_control0(alu_control0), .alu_control1(alu_control1), .sub(sub),
    .stl(stl), .adder_cin(adder_cin), .b_mux0(b_mux0), .b_mux1(b_mux1),
    .a_mux(a_mux), .mux3_0(mux3_0), .mux3_1(mux3_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  assign ctrl_obs = {alu_control1, alu_control0, sub, stl, adder_cin,
                     b_mux1, b_mux0, a_mux, mux3_1, mux3_0};

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  bsel;
    logic        asel;
    logic [1:0]  osel;
    logic [15:0] res;
    logic        zero;
    logic [4:0]  dec;   // {ctrl1, ctrl0, sub, stl, cin}
    int          hold;
    int          idle;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkpos);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst ctrl", 32'(ctrl_obs), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rsp_data", 32'(rsp_data), 32'd0);
    check("rst rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst op_count", 32'(op_count), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    last_ctrl = 10'd0;
    exp_cnt = 0;
  endtask

  task automatic run_op(input vec_t v);
    logic        legal;
    logic [15:0] exp_data;
    int          n;
    legal    = (v.op < 3'd6);
    exp_data = legal ? v.res : 16'h0000;
    check("pre-accept req_ready", 32'(req_ready), 32'd1);
    req_op = v.op; req_bsel = v.bsel; req_asel = v.asel; req_osel = v.osel;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    alu_result = ~v.res;
    alu_zero   = ~v.zero;
    tick();
    req_valid = 1'b0;
    req_op = 3'b000; req_bsel = 2'b00; req_asel = 1'b0; req_osel = 2'b00;
    if (legal) last_ctrl = {v.dec, v.bsel, v.asel, v.osel};
    check("ctrl after accept", 32'(ctrl_obs), 32'(last_ctrl));
    check("req_ready after accept", 32'(req_ready), 32'd0);
    check("busy after accept", 32'(busy), 32'd1);
    // Only the capture edge carries the real result; decoys elsewhere.
    n = 0;
    while (!rsp_valid && n < LAT + 20) begin
      if (n == LAT - 1) begin
        alu_result = v.res;
        alu_zero   = v.zero;
      end else begin
        alu_result = ~v.res;
        alu_zero   = ~v.zero;
      end
      tick();
      n++;
    end
    check("response latency", 32'(n), legal ? 32'(LAT) : 32'd0);
    alu_result = v.res ^ 16'h1234;
    alu_zero   = ~v.zero;
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_err", 32'(rsp_err), legal ? 32'd0 : 32'd1);
    if (legal) check("rsp_zero", 32'(rsp_zero), 32'(v.zero));
    check("ctrl in DONE", 32'(ctrl_obs), 32'(last_ctrl));
    for (int i = 0; i < v.hold; i++) begin
      tick();
      check("hold rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold rsp_data", 32'(rsp_data), 32'(exp_data));
      if (legal) check("hold rsp_zero", 32'(rsp_zero), 32'(v.zero));
      check("hold req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    check("rsp_valid cleared", 32'(rsp_valid), 32'd0);
    check("op_count", 32'(op_count), 32'(exp_cnt));
    check("req_ready back", 32'(req_ready), 32'd1);
    check("busy cleared", 32'(busy), 32'd0);
    for (int i = 0; i < v.idle; i++) begin
      tick();
      check("idle ctrl hold", 32'(ctrl_obs), 32'(last_ctrl));
    end
  endtask

  initial begin
    vec_t w;
    //             op      bsel   asel  osel   res       zero  dec        hold idle
    vecs[0] = '{3'b000, 2'b01, 1'b1, 2'b00, 16'h00F0, 1'b0, 5'b00_000, 0, 0};
    vecs[1] = '{3'b100, 2'b10, 1'b0, 2'b01, 16'h0000, 1'b1, 5'b10_101, 5, 0};
    vecs[2] = '{3'b010, 2'b00, 1'b1, 2'b10, 16'h1357, 1'b0, 5'b10_000, 0, 0};
    vecs[3] = '{3'b101, 2'b11, 1'b0, 2'b11, 16'h0001, 1'b0, 5'b11_011, 0, 3};
    vecs[4] = '{3'b001, 2'b01, 1'b0, 2'b01, 16'h5A5A, 1'b0, 5'b01_000, 0, 0};
    vecs[5] = '{3'b111, 2'b00, 1'b1, 2'b11, 16'hBEEF, 1'b0, 5'b00_000, 2, 1};
    vecs[6] = '{3'b011, 2'b10, 1'b1, 2'b00, 16'hFFFF, 1'b0, 5'b10_001, 0, 0};
    vecs[7] = '{3'b110, 2'b11, 1'b1, 2'b10, 16'hCAFE, 1'b1, 5'b00_000, 0, 1};

    req_valid = 1'b0; req_op = 3'b000; req_bsel = 2'b00; req_asel = 1'b0;
    req_osel = 2'b00; alu_result = 16'h0000; alu_zero = 1'b0; rsp_ready = 1'b0;
    do_reset();

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Reset while WAIT counter reads 5, then a full-latency ADD.
    req_op = 3'b010; req_bsel = 2'b01; req_asel = 1'b1; req_osel = 2'b01;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid-op busy", 32'(busy), 32'd1);
    repeat (11) tick();
    check("mid-op still waiting", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst ctrl", 32'(ctrl_obs), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst op_count", 32'(op_count), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    last_ctrl = 10'd0;
    exp_cnt = 0;
    run_op(vecs[2]);

    // op_count wrap over 16 back-to-back handshakes.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = vecs[i % 8];
      w.hold = 0;
      w.idle = 0;
      run_op(w);
    end
    check("op_count wrapped", 32'(op_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
